// File: rtl/spike_rate_decoder_pkg.sv
// Width derivations and flat-bus field helpers shared by the spike decoder,
// the neuron bank and the readout logic.
package spike_rate_decoder_pkg;

  // A count can reach 2^window_bits, so it needs one bit more than a step index.
  function automatic int count_w(input int window_bits);
    return window_bits + 1;
  endfunction

  function automatic int idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // LSB position of channel ch inside a flat bus of width-bit fields.
  function automatic int field_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/spike_argmax.sv
// Combinational argmax over packed per-channel counts; ties resolve to the
// lowest channel index, and all-zero counts yield channel 0.
module spike_argmax
  import spike_rate_decoder_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int COUNT_W = 5,
  localparam int IDX_W  = idx_w(N_CH)
) (
  input  logic [N_CH*COUNT_W-1:0] counts,
  output logic [IDX_W-1:0]        winner
);

  logic [COUNT_W-1:0] best;

  always_comb begin
    best   = counts[COUNT_W-1:0];
    winner = '0;
    // Strict compare keeps the earlier channel on a tie.
    for (int c = 1; c < N_CH; c++) begin
      if (counts[field_lsb(c, COUNT_W) +: COUNT_W] > best) begin
        best   = counts[field_lsb(c, COUNT_W) +: COUNT_W];
        winner = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes per-channel spike trains over a programmable window into count,
// first-spike step and fired flag, plus an argmax winner, behind a valid/ready register.
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int WINDOW_BITS = 4,
  localparam int COUNT_W    = count_w(WINDOW_BITS),
  localparam int IDX_W      = idx_w(N_CH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [N_CH-1:0]             spikes,
  input  logic [WINDOW_BITS-1:0]      window_len,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_CH*COUNT_W-1:0]     spike_count,
  output logic [N_CH*WINDOW_BITS-1:0] first_spike,
  output logic [N_CH-1:0]             fired,
  output logic [IDX_W-1:0]            winner,
  output logic                        overrun
);

  logic [WINDOW_BITS-1:0] step;
  logic [WINDOW_BITS-1:0] len_q;
  logic [WINDOW_BITS-1:0] cur_len;
  logic [COUNT_W-1:0]     cnt       [N_CH];
  logic [COUNT_W-1:0]     cnt_nxt   [N_CH];
  logic [WINDOW_BITS-1:0] first_acc [N_CH];
  logic [WINDOW_BITS-1:0] first_nxt [N_CH];
  logic [N_CH-1:0]        fired_acc;
  logic [N_CH-1:0]        fired_nxt;
  logic [N_CH*COUNT_W-1:0]     count_flat;
  logic [N_CH*WINDOW_BITS-1:0] first_flat;
  logic [IDX_W-1:0]       win_nxt;
  logic                   close;
  logic                   load;

  // Accumulators including this cycle's spikes: the final result on a close cycle.
  always_comb begin
    cur_len    = (step == '0) ? window_len : len_q;
    close      = enable && (step == cur_len);
    load       = close && (!out_valid || out_ready);
    fired_nxt  = fired_acc | spikes;
    count_flat = '0;
    first_flat = '0;
    for (int c = 0; c < N_CH; c++) begin
      cnt_nxt[c]   = cnt[c] + {{(COUNT_W-1){1'b0}}, spikes[c]};
      first_nxt[c] = (!fired_acc[c] && spikes[c]) ? step : first_acc[c];
      count_flat[field_lsb(c, COUNT_W) +: COUNT_W]         = cnt_nxt[c];
      first_flat[field_lsb(c, WINDOW_BITS) +: WINDOW_BITS] = first_nxt[c];
    end
  end

  spike_argmax #(
    .N_CH    (N_CH),
    .COUNT_W (COUNT_W)
  ) u_argmax (
    .counts (count_flat),
    .winner (win_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      step        <= '0;
      len_q       <= '0;
      fired_acc   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        cnt[c]       <= '0;
        first_acc[c] <= '0;
      end
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      spike_count <= '0;
      first_spike <= '0;
      fired       <= '0;
      winner      <= '0;
    end else begin
      if (enable) begin
        if (step == '0) len_q <= window_len;
        if (close) begin
          step      <= '0;
          fired_acc <= '0;
          for (int c = 0; c < N_CH; c++) begin
            cnt[c]       <= '0;
            first_acc[c] <= '0;
          end
        end else begin
          step      <= step + 1'b1;
          fired_acc <= fired_nxt;
          for (int c = 0; c < N_CH; c++) begin
            cnt[c]       <= cnt_nxt[c];
            first_acc[c] <= first_nxt[c];
          end
        end
      end

      // A close that cannot load means a result is pending and not being taken.
      if (load) begin
        out_valid   <= 1'b1;
        spike_count <= count_flat;
        first_spike <= first_flat;
        fired       <= fired_nxt;
        winner      <= win_nxt;
      end else if (close) begin
        overrun     <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed and random checks of spike_rate_decoder against a window-list reference model.
module tb_spike_rate_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  spikes;
  logic [3:0]  window_len;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] spike_count;
  logic [15:0] first_spike;
  logic [3:0]  fired;
  logic [1:0]  winner;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the whole current window kept as a list of spike vectors.
  logic [3:0]  win_q[$];
  int          mlen;
  logic        ev, eo;
  logic [19:0] ecnt;
  logic [15:0] efirst;
  logic [3:0]  efired;
  logic [1:0]  ewin;

  always #5 clk = ~clk;

  spike_rate_decoder #(.N_CH(4), .WINDOW_BITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .spikes      (spikes),
    .window_len  (window_len),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .spike_count (spike_count),
    .first_spike (first_spike),
    .fired       (fired),
    .winner      (winner),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compute_result();
    int cnts[4];
    int best;
    for (int c = 0; c < 4; c++) begin
      int f;
      cnts[c] = 0;
      f = -1;
      for (int i = 0; i < win_q.size(); i++) begin
        if (win_q[i][c]) begin
          cnts[c]++;
          if (f < 0) f = i;
        end
      end
      ecnt[c*5 +: 5]   = 5'(cnts[c]);
      efirst[c*4 +: 4] = (f < 0) ? 4'd0 : 4'(f);
      efired[c]        = (cnts[c] > 0);
    end
    best = 0;
    for (int c = 1; c < 4; c++) if (cnts[c] > cnts[best]) best = c;
    ewin = 2'(best);
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [3:0] sp,
                            input logic [3:0] wl, input logic rdy);
    logic closed;
    closed = 1'b0;
    if (rst) begin
      win_q.delete();
      ev = 0; eo = 0; ecnt = '0; efirst = '0; efired = '0; ewin = '0;
    end else begin
      if (en) begin
        if (win_q.size() == 0) mlen = int'(wl);
        win_q.push_back(sp);
        if (win_q.size() == mlen + 1) closed = 1'b1;
      end
      if (closed) begin
        if (!ev || rdy) begin
          compute_result();
          ev = 1'b1;
        end else begin
          eo = 1'b1;
        end
        win_q.delete();
      end else if (ev && rdy) begin
        ev = 1'b0;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic en, input logic [3:0] sp,
                     input logic [3:0] wl, input logic rdy);
    reset = rst; enable = en; spikes = sp; window_len = wl; out_ready = rdy;
    @(posedge clk);
    #1;
    model_step(rst, en, sp, wl, rdy);
    chk("out_valid", out_valid, ev);
    chk("overrun", overrun, eo);
    if (ev) begin
      chk("spike_count", spike_count, ecnt);
      chk("first_spike", first_spike, efirst);
      chk("fired", fired, efired);
      chk("winner", winner, ewin);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; spikes = '0; window_len = '0; out_ready = 1'b0;
    cyc(1, 0, 4'b0000, 4'd0, 0);
    cyc(1, 0, 4'b0000, 4'd0, 0);
    chk("rst_count", spike_count, 0);
    chk("rst_first", first_spike, 0);
    chk("rst_fired", fired, 0);
    chk("rst_winner", winner, 0);

    // Basic rate/latency decode, 4-step window on ch0.
    cyc(0, 1, 4'b0001, 4'd3, 1);
    cyc(0, 1, 4'b0000, 4'd3, 1);
    cyc(0, 1, 4'b0001, 4'd3, 1);
    cyc(0, 1, 4'b0001, 4'd3, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_cnt0", spike_count[4:0], 3);
    chk("t1_first0", first_spike[3:0], 0);
    chk("t1_fired", fired, 4'b0001);
    chk("t1_winner", winner, 0);
    cyc(0, 0, 4'b0000, 4'd0, 1);

    // Full 16-step window without count wrap.
    for (int i = 0; i < 16; i++) cyc(0, 1, 4'b0100, 4'd15, 1);
    chk("t2_cnt2", spike_count[14:10], 16);
    chk("t2_first2", first_spike[11:8], 0);
    chk("t2_winner", winner, 2);
    cyc(0, 0, 4'b0000, 4'd0, 1);

    // Tie between ch1 and ch3 with different first-spike steps.
    cyc(0, 1, 4'b0000, 4'd3, 1);
    cyc(0, 1, 4'b1000, 4'd3, 1);
    cyc(0, 1, 4'b0010, 4'd3, 1);
    cyc(0, 1, 4'b1010, 4'd3, 1);
    chk("t3_winner", winner, 1);
    chk("t3_first3", first_spike[15:12], 1);
    chk("t3_first1", first_spike[7:4], 2);
    cyc(0, 0, 4'b0000, 4'd0, 1);

    // Close and accept in the same cycle.
    cyc(0, 1, 4'b0001, 4'd1, 0);
    cyc(0, 1, 4'b0001, 4'd1, 0);
    cyc(0, 1, 4'b0010, 4'd1, 0);
    cyc(0, 1, 4'b0010, 4'd1, 1);
    chk("t4_valid", out_valid, 1);
    chk("t4_overrun", overrun, 0);
    chk("t4_fired", fired, 4'b0010);
    chk("t4_winner", winner, 1);
    cyc(0, 0, 4'b0000, 4'd0, 1);

    // Overrun: second window dropped while the first is held.
    cyc(0, 1, 4'b0001, 4'd1, 0);
    cyc(0, 1, 4'b0001, 4'd1, 0);
    cyc(0, 1, 4'b1000, 4'd1, 0);
    cyc(0, 1, 4'b1000, 4'd1, 0);
    chk("t5_held_fired", fired, 4'b0001);
    chk("t5_overrun", overrun, 1);
    cyc(0, 0, 4'b0000, 4'd0, 1);
    chk("t5_valid_clr", out_valid, 0);
    chk("t5_overrun_sticky", overrun, 1);
    cyc(0, 1, 4'b0100, 4'd1, 0);
    cyc(0, 1, 4'b0100, 4'd1, 0);

    // Reset at step 2 with a result pending, then a fresh 4-step window.
    cyc(0, 1, 4'b0001, 4'd3, 0);
    cyc(0, 1, 4'b0001, 4'd3, 0);
    cyc(1, 1, 4'b0001, 4'd3, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_overrun", overrun, 0);
    cyc(0, 1, 4'b0010, 4'd3, 0);
    cyc(0, 1, 4'b0010, 4'd3, 0);
    cyc(0, 1, 4'b0000, 4'd3, 0);
    cyc(0, 1, 4'b0010, 4'd3, 0);
    chk("t6_cnt1", spike_count[9:5], 3);
    chk("t6_cnt0", spike_count[4:0], 0);
    chk("t6_fired", fired, 4'b0010);
    cyc(0, 0, 4'b0000, 4'd0, 1);

    // Randomized traffic with sparse enables, random ready and occasional reset.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 3) != 0),
          4'($urandom),
          4'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
